pid_uk_accum: RTL

Downstream stage of the PID increment computer. It consumes each signed increment d_uk and forms the absolute control output u(k) = u(k-1) + d_uk. The result is clamped to programmable limits, and overflow is guarded against. u(k) is presented to the actuator/PWM stage with a one-cycle valid strobe. A valid/ready handshake sits on the input side, and a synchronous clear/preset is provided for bumpless start.

---
 rtl/pid_uk_accum.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pid_uk_accum.sv
// Absolute-output accumulator behind the PID increment stage.
// It forms u(k) = u(k-1) + d_uk with clamping, an overflow-proof sum, and preset/clear.
module pid_uk_accum #(
  parameter int DUK_W = 24,
  parameter int UK_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [UK_W-1:0]  preset,
  input  logic [UK_W-1:0]  uk_min,
  input  logic [UK_W-1:0]  uk_max,
  input  logic             duk_valid,
  output logic             duk_ready,
  input  logic [DUK_W-1:0] d_uk,
  output logic [UK_W-1:0]  uk,
  output logic             uk_valid,
  output logic             sat_hi,
  output logic             sat_lo,
  output logic             cfg_err
);

  localparam int SW = DUK_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_CLAMP, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [DUK_W-1:0]   duk_q, duk_d;
  logic [SW-1:0]      sum_q, sum_d;
  logic [UK_W-1:0]    uk_q, uk_d;
  logic               uk_valid_q, uk_valid_d;
  logic               sat_hi_q, sat_hi_d;
  logic               sat_lo_q, sat_lo_d;
  logic               cfg_err_q, cfg_err_d;

  logic signed [SW-1:0]   uk_ext, duk_ext, min_ext, max_ext, sum_s;
  logic signed [UK_W-1:0] min_s, max_s;

  // The sum is two bits wider than d_uk so no operand combination can wrap.
  assign uk_ext  = {{(SW-UK_W){uk_q[UK_W-1]}}, uk_q};
  assign duk_ext = {{2{duk_q[DUK_W-1]}}, duk_q};
  assign min_ext = {{(SW-UK_W){uk_min[UK_W-1]}}, uk_min};
  assign max_ext = {{(SW-UK_W){uk_max[UK_W-1]}}, uk_max};
  assign sum_s   = sum_q;
  assign min_s   = uk_min;
  assign max_s   = uk_max;

  assign duk_ready = (state_q == S_IDLE) && !clr && !rst;

  always_comb begin
    state_d    = state_q;
    duk_d      = duk_q;
    sum_d      = sum_q;
    uk_d       = uk_q;
    uk_valid_d = uk_valid_q;
    sat_hi_d   = sat_hi_q;
    sat_lo_d   = sat_lo_q;
    cfg_err_d  = cfg_err_q;

    case (state_q)
      S_IDLE: begin
        if (duk_valid && duk_ready) begin
          duk_d   = d_uk;
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        sum_d   = uk_ext + duk_ext;
        state_d = S_CLAMP;
      end
      S_CLAMP: begin
        sat_hi_d   = 1'b0;
        sat_lo_d   = 1'b0;
        cfg_err_d  = 1'b0;
        uk_valid_d = 1'b1;
        if (min_s > max_s) begin
          cfg_err_d = 1'b1;
        end else if (sum_s > max_ext) begin
          uk_d     = uk_max;
          sat_hi_d = 1'b1;
        end else if (sum_s < min_ext) begin
          uk_d     = uk_min;
          sat_lo_d = 1'b1;
        end else begin
          uk_d = sum_q[UK_W-1:0];
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        uk_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear wins over any in-flight sample and loads the preset unclamped.
    if (clr) begin
      state_d    = S_IDLE;
      uk_d       = preset;
      uk_valid_d = 1'b0;
      sat_hi_d   = 1'b0;
      sat_lo_d   = 1'b0;
      cfg_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      duk_q      <= '0;
      sum_q      <= '0;
      uk_q       <= '0;
      uk_valid_q <= 1'b0;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      duk_q      <= duk_d;
      sum_q      <= sum_d;
      uk_q       <= uk_d;
      uk_valid_q <= uk_valid_d;
      sat_hi_q   <= sat_hi_d;
      sat_lo_q   <= sat_lo_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign uk       = uk_q;
  assign uk_valid = uk_valid_q;
  assign sat_hi   = sat_hi_q;
  assign sat_lo   = sat_lo_q;
  assign cfg_err  = cfg_err_q;

endmodule
